// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op codes, state encoding and default sizes for the iterative shifter
package shift_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int AMT_W_DEF = 4;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t SH_PASS = 2'b00;
  localparam shift_op_t SH_LSL  = 2'b01;
  localparam shift_op_t SH_LSR  = 2'b10;
  localparam shift_op_t SH_ASR  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step1.sv
// rtl/shift_step1.sv - combinational one-bit shift step returning the next word and the bit shifted out
module shift_step1
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data,
  input  shift_op_t        op,
  output logic [WIDTH-1:0] next_data,
  output logic             shifted_out
);

  always_comb begin
    next_data   = data;
    shifted_out = 1'b0;
    case (op)
      SH_LSL: begin
        next_data   = {data[WIDTH-2:0], 1'b0};
        shifted_out = data[WIDTH-1];
      end
      SH_LSR: begin
        next_data   = {1'b0, data[WIDTH-1:1]};
        shifted_out = data[0];
      end
      SH_ASR: begin
        next_data   = {data[WIDTH-1], data[WIDTH-1:1]};
        shifted_out = data[0];
      end
      default: begin
        next_data   = data;
        shifted_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// rtl/iter_shift_unit.sv - one-bit-per-clock shift engine with valid/ready in and out; ITER_SHIFT_CARRY_EN adds out_carry
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  shift_op_t        in_op,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef ITER_SHIFT_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  shift_op_t        work_op;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  shift_step1 #(.WIDTH(WIDTH)) u_step (
    .data        (work),
    .op          (work_op),
    .next_data   (step_data),
    .shifted_out (step_carry)
  );

`ifdef ITER_SHIFT_CARRY_EN
  logic carry;
`else
  logic unused_step_carry;
  assign unused_step_carry = step_carry;
`endif

  // The working register doubles as the result register, so out_data is stable throughout DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      work    <= '0;
      work_op <= SH_PASS;
      count   <= '0;
`ifdef ITER_SHIFT_CARRY_EN
      carry   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work    <= in_data;
            work_op <= in_op;
            count   <= in_amt;
`ifdef ITER_SHIFT_CARRY_EN
            carry   <= 1'b0;
`endif
            if (in_op == SH_PASS || in_amt == '0) begin
              state <= ST_DONE;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          work  <= step_data;
          count <= count - AMT_ONE;
`ifdef ITER_SHIFT_CARRY_EN
          carry <= step_carry;
`endif
          // Leave on the amt-th step so the result is visible amt+1 cycles after accept.
          if (count == AMT_ONE) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = work;
`ifdef ITER_SHIFT_CARRY_EN
  assign out_carry = carry;
`endif

endmodule
